// File: rtl/robot_ctrl_axi_lite_slave.sv
// -----------------------------------------------------------------------------
// robot_ctrl_axi_lite_slave
//
// AXI4-Lite slave holding the Robot_Controller register bank: four 32-bit
// read/write control registers. Register contents are driven straight out to
// the robot datapath (ctrl_reg0..3), and reg_wr_pulse[n] pulses for one cycle
// alongside the write response for register n.
//
// Handshake rule (all five channels): a transfer happens on a rising clock
// edge where VALID and READY are both 1. A source holds VALID (and its
// payload) until that edge; READY may change freely and never depends
// combinationally on the same channel's VALID.
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESETN     clock, synchronous active-low reset
//   S_AXI_AW*  / S_AXI_W* / S_AXI_B*   write address, data, response
//   S_AXI_AR*  / S_AXI_R*              read address, read data
//   ctrl_reg0..3                   live register contents
//   reg_wr_pulse                   one-hot per-register write strobe
//   dbg_state_o                    {read FSM state, write FSM state}
//
// ADDR[3:2] selects the register; ADDR[1:0] and the PROT fields are ignored.
// Every access answers OKAY.
// -----------------------------------------------------------------------------
module robot_ctrl_axi_lite_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl_reg3,
  output logic [3:0]                      reg_wr_pulse,
  output logic [1:0]                      dbg_state_o
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [0:0] WR_IDLE = 1'b0;
  localparam logic [0:0] WR_RESP = 1'b1;
  localparam logic [0:0] RD_IDLE = 1'b0;
  localparam logic [0:0] RD_DATA = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // ready_en_q keeps every READY low while reset is asserted; it rises on the
  // first edge after release so the READYs appear one cycle later.
  logic              ready_en_q,  ready_en_d;

  logic [0:0]        wr_state_q,  wr_state_d;
  logic              aw_held_q,   aw_held_d;
  logic              w_held_q,    w_held_d;
  logic [1:0]        aw_sel_q,    aw_sel_d;
  logic [DW-1:0]     wdata_q,     wdata_d;
  logic [STRB_W-1:0] wstrb_q,     wstrb_d;
  logic              bvalid_q,    bvalid_d;
  logic [3:0]        pulse_q,     pulse_d;

  logic [0:0]        rd_state_q,  rd_state_d;
  logic              rvalid_q,    rvalid_d;
  logic [DW-1:0]     rdata_q,     rdata_d;

  logic [DW-1:0]     regs_q [4];
  logic [DW-1:0]     regs_d [4];

  logic aw_hs;
  logic w_hs;
  logic ar_hs;

  // Address low bits and protection fields carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign S_AXI_AWREADY = ready_en_q & (wr_state_q == WR_IDLE) & ~aw_held_q;
  assign S_AXI_WREADY  = ready_en_q & (wr_state_q == WR_IDLE) & ~w_held_q;
  assign S_AXI_ARREADY = ready_en_q & (rd_state_q == RD_IDLE);

  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;

  assign ctrl_reg0     = regs_q[0];
  assign ctrl_reg1     = regs_q[1];
  assign ctrl_reg2     = regs_q[2];
  assign ctrl_reg3     = regs_q[3];
  assign reg_wr_pulse  = pulse_q;
  assign dbg_state_o   = {rd_state_q, wr_state_q};

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  // AW and W are captured independently; the register update fires on the
  // edge after both are held, so a same-edge AW+W pair commits one cycle
  // later, exactly like a staggered pair.
  always_comb begin
    ready_en_d = 1'b1;
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    aw_sel_d   = aw_sel_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    pulse_d    = 4'b0000;
    for (int r = 0; r < 4; r++) begin
      regs_d[r] = regs_q[r];
    end

    if (wr_state_q == WR_IDLE) begin
      if (aw_hs) begin
        aw_held_d = 1'b1;
        aw_sel_d  = S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
        w_held_d = 1'b1;
        wdata_d  = S_AXI_WDATA;
        wstrb_d  = S_AXI_WSTRB;
      end
      if (aw_held_q && w_held_q) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wstrb_q[b]) begin
            regs_d[aw_sel_q][8*b +: 8] = wdata_q[8*b +: 8];
          end
        end
        pulse_d[aw_sel_q] = 1'b1;
        bvalid_d          = 1'b1;
        wr_state_d        = WR_RESP;
      end
    end else begin
      // WR_RESP: response held until the master takes it.
      if (S_AXI_BREADY) begin
        bvalid_d   = 1'b0;
        aw_held_d  = 1'b0;
        w_held_d   = 1'b0;
        wr_state_d = WR_IDLE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  // RDATA samples regs_q, so a read on the same edge as a write returns the
  // value from before that write.
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    if (rd_state_q == RD_IDLE) begin
      if (ar_hs) begin
        rdata_d    = regs_q[S_AXI_ARADDR[3:2]];
        rvalid_d   = 1'b1;
        rd_state_d = RD_DATA;
      end
    end else begin
      if (S_AXI_RREADY) begin
        rvalid_d   = 1'b0;
        rd_state_d = RD_IDLE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential
  // ---------------------------------------------------------------------------
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      ready_en_q <= 1'b0;
      wr_state_q <= WR_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_sel_q   <= 2'b00;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      pulse_q    <= 4'b0000;
      rd_state_q <= RD_IDLE;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      for (int r = 0; r < 4; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      ready_en_q <= ready_en_d;
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      aw_sel_q   <= aw_sel_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      pulse_q    <= pulse_d;
      rd_state_q <= rd_state_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      for (int r = 0; r < 4; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

endmodule
